sata_oob_ctrl: RTL

- Supervisory FSM directly upstream of the SATA OOB unit.
- Waits for GTX readiness, then issues oob_start pulses. It grants device-initiated COMINIT, consumes the OOB status outputs, and retries with back-off.
- After link-up it monitors for electrical-idle link loss.
- Presents a single phy_ready level plus retry/cause status to the link layer.

---
 rtl/sata_oob_pkg.sv | 42 ++++
 rtl/sata_oob_ctrl_if.sv | 39 +++
 rtl/sata_oob_ctrl_timer.sv | 43 ++++
 rtl/sata_oob_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sata_oob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sata_oob_pkg
//  Description : Shared types and constants for the SATA OOB supervisor:
//                state encoding, last_cause codes, default timing values and
//                a saturating-increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sata_oob_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_OOB  = 3'd2,
        ST_WAIT_LINK = 3'd3,
        ST_READY     = 3'd4,
        ST_BACKOFF   = 3'd5,
        ST_FAILED    = 3'd6
    } oob_state_t;

    localparam logic [2:0] c_CAUSE_NONE         = 3'd0;
    localparam logic [2:0] c_CAUSE_SILENCE      = 3'd1;
    localparam logic [2:0] c_CAUSE_INCOMPATIBLE = 3'd2;
    localparam logic [2:0] c_CAUSE_ERROR        = 3'd3;
    localparam logic [2:0] c_CAUSE_LINK_TIMEOUT = 3'd4;
    localparam logic [2:0] c_CAUSE_WATCHDOG     = 3'd5;
    localparam logic [2:0] c_CAUSE_ELECIDLE     = 3'd6;

    localparam int c_TIMER_W           = 20;
    localparam int c_DEF_RETRY_DELAY   = 1024;
    localparam int c_DEF_LINK_TIMEOUT  = 64;
    localparam int c_DEF_OOB_WATCHDOG  = 20'hFFFFF;
    localparam int c_DEF_ELECIDLE_LOSS = 256;
    localparam int c_DEF_MAX_RETRIES   = 8;

    // Four-bit increment that sticks at 15
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sata_oob_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sata_oob_ctrl_if
//  Description : Bundle between the OOB supervisor, the GTX/OOB unit and the
//                link layer. master = supervisor side, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sata_oob_ctrl_if;
    logic       gtx_ready;
    logic       oob_done;
    logic       link_up;
    logic       oob_error;
    logic       oob_silence;
    logic       oob_incompatible;
    logic       cominit_req;
    logic       rxelecidle;
    logic       oob_start;
    logic       cominit_allow;
    logic       phy_ready;
    logic       link_lost;
    logic [3:0] retry_cnt;
    logic [2:0] last_cause;
    logic       ctrl_failed;

    modport master (
        input  gtx_ready, oob_done, link_up, oob_error, oob_silence,
               oob_incompatible, cominit_req, rxelecidle,
        output oob_start, cominit_allow, phy_ready, link_lost, retry_cnt,
               last_cause, ctrl_failed
    );

    modport slave (
        output gtx_ready, oob_done, link_up, oob_error, oob_silence,
               oob_incompatible, cominit_req, rxelecidle,
        input  oob_start, cominit_allow, phy_ready, link_lost, retry_cnt,
               last_cause, ctrl_failed
    );
endinterface
`default_nettype wire

// File: rtl/sata_oob_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module      : oob_ctrl_timer
//  Description : Saturating state timer with synchronous clear. Flags the
//                last clock of the watchdog, link-timeout and back-off windows
//                (count == N-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module oob_ctrl_timer #(
    parameter int WIDTH         = 20,
    parameter int WATCHDOG_CLKS = 20'hFFFFF,
    parameter int LINK_CLKS     = 64,
    parameter int RETRY_CLKS    = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_watchdog_hit,
    output logic o_link_hit,
    output logic o_retry_hit
);
    localparam logic [WIDTH-1:0] c_WD_TERM    = WIDTH'(WATCHDOG_CLKS - 1);
    localparam logic [WIDTH-1:0] c_LINK_TERM  = WIDTH'(LINK_CLKS - 1);
    localparam logic [WIDTH-1:0] c_RETRY_TERM = WIDTH'(RETRY_CLKS - 1);

    logic [WIDTH-1:0] r_count;

    // Count clocks in the current state; stop at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_watchdog_hit = (r_count == c_WD_TERM);
    assign o_link_hit     = (r_count == c_LINK_TERM);
    assign o_retry_hit    = (r_count == c_RETRY_TERM);
endmodule
`default_nettype wire

// File: rtl/sata_oob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sata_oob_ctrl
//  Description : Supervisory FSM ahead of the SATA OOB unit. Waits for GTX
//                readiness, issues oob_start, grants device COMINIT, retries
//                with back-off, and watches for electrical-idle link loss.
//                Optional retry limit (FAILED state) enabled by the macro
//                OOB_CTRL_RETRY_LIMIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sata_oob_ctrl
    import sata_oob_pkg::*;
#(
    parameter int RETRY_DELAY   = c_DEF_RETRY_DELAY,
    parameter int LINK_TIMEOUT  = c_DEF_LINK_TIMEOUT,
    parameter int OOB_WATCHDOG  = c_DEF_OOB_WATCHDOG,
    parameter int ELECIDLE_LOSS = c_DEF_ELECIDLE_LOSS
`ifdef OOB_CTRL_RETRY_LIMIT_EN
    ,
    parameter int MAX_RETRIES   = c_DEF_MAX_RETRIES
`endif
) (
    input  logic            clk,
    input  logic            rst,
    sata_oob_ctrl_if.master oob
);
    localparam int c_EI_W = $clog2(ELECIDLE_LOSS + 1);

    oob_state_t        r_state;
    oob_state_t        w_state_next;
    logic              w_grant;
    logic              w_lost;
    logic              w_to_backoff;
    logic              w_timer_clr;
    logic              w_wd_hit;
    logic              w_link_hit;
    logic              w_retry_hit;
    logic              w_ei_hit;
    logic [3:0]        r_retry_cnt;
    logic [3:0]        w_retry_next;
    logic [2:0]        r_last_cause;
    logic [2:0]        w_cause_next;
    logic [c_EI_W-1:0] r_ei_cnt;
    logic [c_EI_W-1:0] w_ei_next;
    logic              r_oob_start;
    logic              r_cominit_allow;
    logic              r_phy_ready;
    logic              r_link_lost;

    assign w_ei_next   = r_ei_cnt + c_EI_W'(1);
    assign w_ei_hit    = oob.rxelecidle && (w_ei_next == c_EI_W'(ELECIDLE_LOSS));
    assign w_timer_clr = (w_state_next != r_state);

    oob_ctrl_timer #(
        .WIDTH         (c_TIMER_W),
        .WATCHDOG_CLKS (OOB_WATCHDOG),
        .LINK_CLKS     (LINK_TIMEOUT),
        .RETRY_CLKS    (RETRY_DELAY)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (w_timer_clr),
        .o_watchdog_hit (w_wd_hit),
        .o_link_hit     (w_link_hit),
        .o_retry_hit    (w_retry_hit)
    );

    // Next state, grant/loss strobes and status updates
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_lost       = 1'b0;
        w_to_backoff = 1'b0;
        w_retry_next = r_retry_cnt;
        w_cause_next = r_last_cause;
        if (!oob.gtx_ready) begin
            // Losing the transceiver trumps everything; status is kept
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (oob.cominit_req) w_grant = 1'b1;
                    else                 w_state_next = ST_START;
                end
                ST_START: w_state_next = ST_WAIT_OOB;
                ST_WAIT_OOB: begin
                    if (oob.oob_done) begin
                        w_state_next = ST_WAIT_LINK;
                    end else if (oob.oob_silence) begin
                        w_to_backoff = 1'b1;
                        w_cause_next = c_CAUSE_SILENCE;
                    end else if (oob.oob_incompatible) begin
                        w_to_backoff = 1'b1;
                        w_cause_next = c_CAUSE_INCOMPATIBLE;
                    end else if (oob.oob_error) begin
                        w_to_backoff = 1'b1;
                        w_cause_next = c_CAUSE_ERROR;
                    end else if (w_wd_hit) begin
                        w_to_backoff = 1'b1;
                        w_cause_next = c_CAUSE_WATCHDOG;
                    end
                end
                ST_WAIT_LINK: begin
                    if (oob.link_up) begin
                        w_state_next = ST_READY;
                        w_retry_next = 4'd0;
                    end else if (w_link_hit) begin
                        w_to_backoff = 1'b1;
                        w_cause_next = c_CAUSE_LINK_TIMEOUT;
                    end
                end
                ST_READY: begin
                    // Loss from READY is not a failed attempt: no retry count
                    if (w_ei_hit) begin
                        w_state_next = ST_BACKOFF;
                        w_lost       = 1'b1;
                        w_cause_next = c_CAUSE_ELECIDLE;
                    end else if (oob.cominit_req) begin
                        w_grant = 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (oob.cominit_req)  w_grant = 1'b1;
                    else if (w_retry_hit) w_state_next = ST_START;
                end
                ST_FAILED: begin
`ifdef OOB_CTRL_RETRY_LIMIT_EN
                    if (oob.cominit_req) begin
                        w_grant      = 1'b1;
                        w_retry_next = 4'd0;
                    end
`else
                    w_state_next = ST_IDLE;
`endif
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
        if (w_to_backoff) begin
            w_retry_next = sat_inc4(r_retry_cnt);
`ifdef OOB_CTRL_RETRY_LIMIT_EN
            if (r_retry_cnt == 4'(MAX_RETRIES - 1)) w_state_next = ST_FAILED;
            else                                   w_state_next = ST_BACKOFF;
`else
            w_state_next = ST_BACKOFF;
`endif
        end
        if (w_grant) w_state_next = ST_WAIT_OOB;
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_oob_start     <= 1'b0;
            r_cominit_allow <= 1'b0;
            r_phy_ready     <= 1'b0;
            r_link_lost     <= 1'b0;
            r_retry_cnt     <= 4'd0;
            r_last_cause    <= c_CAUSE_NONE;
        end else begin
            r_state         <= w_state_next;
            r_oob_start     <= (w_state_next == ST_START);
            r_cominit_allow <= w_grant;
            r_phy_ready     <= (w_state_next == ST_READY);
            r_link_lost     <= w_lost;
            r_retry_cnt     <= w_retry_next;
            r_last_cause    <= w_cause_next;
        end
    end

    // Run length of consecutive rxelecidle clocks while READY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ei_cnt <= '0;
        end else if ((r_state == ST_READY) && oob.rxelecidle) begin
            r_ei_cnt <= w_ei_next;
        end else begin
            r_ei_cnt <= '0;
        end
    end

`ifdef OOB_CTRL_RETRY_LIMIT_EN
    logic r_ctrl_failed;

    // Give-up flag tracks residence in FAILED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ctrl_failed <= 1'b0;
        else     r_ctrl_failed <= (w_state_next == ST_FAILED);
    end

    assign oob.ctrl_failed = r_ctrl_failed;
`else
    assign oob.ctrl_failed = 1'b0;
`endif

    assign oob.oob_start     = r_oob_start;
    assign oob.cominit_allow = r_cominit_allow;
    assign oob.phy_ready     = r_phy_ready;
    assign oob.link_lost     = r_link_lost;
    assign oob.retry_cnt     = r_retry_cnt;
    assign oob.last_cause    = r_last_cause;
endmodule
`default_nettype wire
